// File: rtl/frida_seq_pkg.sv
// Shared types and sizing helpers for the FRIDA conversion sequencer.
// The FSM state encoding, phase indices and width functions live here.
package frida_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SAMP,
        S_COMP,
        S_LOGIC,
        S_DONE
    } seq_state_e;

    // Index of each programmable phase duration in the shadow table
    localparam int N_PHASES = 4;
    localparam int PH_INIT  = 0;
    localparam int PH_SAMP  = 1;
    localparam int PH_COMP  = 2;
    localparam int PH_LOGIC = 3;

    function automatic int sel_width(input int n_adc);
        return (n_adc > 1) ? $clog2(n_adc) : 1;
    endfunction

    function automatic int bcnt_width(input int n_bits);
        return $clog2(n_bits + 1);
    endfunction

endpackage

// File: rtl/frida_scan_seq_if.sv
// Result-slot handshake between the sequencer (master) and the consumer
// (slave): one conversion word plus the channel it came from.
interface frida_scan_seq_if #(
    parameter int N_BITS = 8,
    parameter int SEL_W  = 4
) ();

    logic              res_valid;
    logic              res_ready;
    logic [N_BITS-1:0] res_data;
    logic [SEL_W-1:0]  res_chan;

    modport master (
        output res_valid,
        output res_data,
        output res_chan,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_chan,
        output res_ready
    );

endinterface

// File: rtl/frida_chan_pick.sv
// Combinational channel finder: next set mask bit above the current
// channel, the lowest set bit for wrap-around, and a flag when none is above.
module frida_chan_pick
    import frida_seq_pkg::*;
#(
    parameter int N_ADC = 16,
    parameter int SEL_W = sel_width(N_ADC)
) (
    input  logic [N_ADC-1:0] mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] next,
    output logic [SEL_W-1:0] wrapped,
    output logic             none
);

    // Scanning downwards lets the lowest qualifying bit win
    always_comb begin
        next    = '0;
        wrapped = '0;
        none    = 1'b1;
        for (int i = N_ADC - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) > cur)) begin
                next = SEL_W'(i);
                none = 1'b0;
            end
            if (mask[i]) begin
                wrapped = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/frida_scan_seq.sv
// FRIDA conversion sequencer: generates the ADC phase strobes, steps the
// comparator mux over the masked channels and delivers one word per conversion.
module frida_scan_seq
    import frida_seq_pkg::*;
#(
    parameter int N_ADC  = 16,
    parameter int SEL_W  = sel_width(N_ADC),
    parameter int N_BITS = 8,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_en,
    input  logic               cfg_cont,
    input  logic [N_ADC-1:0]   cfg_mask,
    input  logic [CNT_W-1:0]   cfg_t_init,
    input  logic [CNT_W-1:0]   cfg_t_samp,
    input  logic [CNT_W-1:0]   cfg_t_comp,
    input  logic [CNT_W-1:0]   cfg_t_logic,
    input  logic               start,
    output logic               busy,
    output logic               seq_init,
    output logic               seq_samp,
    output logic               seq_comp,
    output logic               seq_logic,
    output logic [SEL_W-1:0]   mux_sel,
    input  logic               comp_in,
    frida_scan_seq_if.master   res,
    output logic               overrun,
    input  logic               ovr_clr
);

    localparam int BCW = bcnt_width(N_BITS);
    localparam logic [BCW-1:0] BITS_TOT = BCW'(N_BITS);

    seq_state_e        state;
    logic [CNT_W-1:0]  ph_cnt;
    logic [CNT_W-1:0]  cur_t;
    logic              ph_last;
    logic [BCW-1:0]    bit_cnt;
    logic [N_BITS-1:0] shift;

    logic              sh_cont;
    logic [N_ADC-1:0]  sh_mask;
    logic [CNT_W-1:0]  sh_t [N_PHASES];

    logic [N_ADC-1:0]  pick_mask;
    logic [SEL_W-1:0]  pick_next;
    logic [SEL_W-1:0]  pick_wrap;
    logic              pick_none;
    logic              start_ok;
    logic              slot_free;

    assign start_ok  = (state == S_IDLE) && cfg_en && start && (|cfg_mask);
    assign slot_free = !res.res_valid || res.res_ready;
    assign busy      = (state != S_IDLE);
    // In IDLE the live mask supplies the first channel; afterwards the shadow copy
    assign pick_mask = (state == S_IDLE) ? cfg_mask : sh_mask;

    frida_chan_pick #(
        .N_ADC (N_ADC),
        .SEL_W (SEL_W)
    ) u_pick (
        .mask    (pick_mask),
        .cur     (mux_sel),
        .next    (pick_next),
        .wrapped (pick_wrap),
        .none    (pick_none)
    );

    // NOTE: shadow config is only ever read after a qualified start has loaded
    // it, so it carries no reset and costs nothing on the reset tree.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            sh_cont        <= cfg_cont;
            sh_mask        <= cfg_mask;
            sh_t[PH_INIT]  <= cfg_t_init;
            sh_t[PH_SAMP]  <= cfg_t_samp;
            sh_t[PH_COMP]  <= cfg_t_comp;
            sh_t[PH_LOGIC] <= cfg_t_logic;
        end
    end

    always_comb begin
        cur_t = '0;
        case (state)
            S_INIT:  cur_t = sh_t[PH_INIT];
            S_SAMP:  cur_t = sh_t[PH_SAMP];
            S_COMP:  cur_t = sh_t[PH_COMP];
            S_LOGIC: cur_t = sh_t[PH_LOGIC];
            default: cur_t = '0;
        endcase
    end

    assign ph_last = (ph_cnt == cur_t);

    // NOTE: every register here uses <= so all updates see the pre-edge values;
    // later assignments in the block deliberately override earlier defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            ph_cnt        <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            mux_sel       <= '0;
            seq_init      <= 1'b0;
            seq_samp      <= 1'b0;
            seq_comp      <= 1'b0;
            seq_logic     <= 1'b0;
            res.res_valid <= 1'b0;
            res.res_data  <= '0;
            res.res_chan  <= '0;
            overrun       <= 1'b0;
        end else begin
            if (res.res_valid && res.res_ready) begin
                res.res_valid <= 1'b0;
            end

            if (!cfg_en) begin
                state <= S_IDLE;
                {seq_init, seq_samp, seq_comp, seq_logic} <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && (|cfg_mask)) begin
                            state    <= S_INIT;
                            seq_init <= 1'b1;
                            ph_cnt   <= '0;
                            bit_cnt  <= '0;
                            mux_sel  <= pick_wrap;
                        end
                    end
                    S_INIT: begin
                        if (ph_last) begin
                            state    <= S_SAMP;
                            seq_init <= 1'b0;
                            seq_samp <= 1'b1;
                            ph_cnt   <= '0;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    S_SAMP: begin
                        if (ph_last) begin
                            state    <= S_COMP;
                            seq_samp <= 1'b0;
                            seq_comp <= 1'b1;
                            ph_cnt   <= '0;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    S_COMP: begin
                        if (ph_last) begin
                            state     <= S_LOGIC;
                            seq_comp  <= 1'b0;
                            seq_logic <= 1'b1;
                            ph_cnt    <= '0;
                            shift     <= {shift[N_BITS-2:0], comp_in};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    S_LOGIC: begin
                        if (ph_last) begin
                            seq_logic <= 1'b0;
                            ph_cnt    <= '0;
                            if (bit_cnt < BITS_TOT) begin
                                state    <= S_COMP;
                                seq_comp <= 1'b1;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        // A full slot stalls single-shot scans; continuous scans drop
                        if (slot_free || sh_cont) begin
                            if (slot_free) begin
                                res.res_valid <= 1'b1;
                                res.res_data  <= shift;
                                res.res_chan  <= mux_sel;
                            end else begin
                                overrun <= 1'b1;
                            end
                            if (pick_none && !sh_cont) begin
                                state <= S_IDLE;
                            end else begin
                                state    <= S_INIT;
                                seq_init <= 1'b1;
                                ph_cnt   <= '0;
                                bit_cnt  <= '0;
                                mux_sel  <= pick_none ? pick_wrap : pick_next;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end

            if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/frida_scan_seq.md
# frida_scan_seq

Parametrised on-chip conversion sequencer and channel scanner for the FRIDA ADC array; it generalises the fixed 16-channel, externally clocked core. It generates the seq_init / seq_samp / seq_comp / seq_logic phase strobes internally with programmable durations. It steps the comparator mux across a masked set of N_ADC channels, in single-shot or continuous mode. Per conversion it shifts the N_BITS comparator decisions into a result word and delivers it with a valid/ready handshake. It sits between the SPI register bank (configuration source) and the ADC array plus compmux.

## Interface
- N_ADC, 16: number of ADC channels (≥2).
- SEL_W, $clog2(N_ADC): mux select width.
- N_BITS, 8: comparison cycles per conversion (result width).
- CNT_W, 8: phase-duration counter width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_en  in  1  block enable; low aborts any activity.
- cfg_cont  in  1  0 = single-shot scan, 1 = continuous scan.
- cfg_mask  in  N_ADC  channel enable mask.
- cfg_t_init, cfg_t_samp, cfg_t_comp, cfg_t_logic  in  CNT_W each  phase length minus one.
- start  in  1  scan request pulse.
- busy  out  1  high whenever not IDLE.
- seq_init, seq_samp, seq_comp, seq_logic  out  1 each  phase strobes to ADC array, registered, one-hot or all-zero.
- mux_sel  out  SEL_W  channel currently converted.
- comp_in  in  1  muxed comparator output.
- res_valid  out  1  result slot full.
- res_ready  in  1  consumer accepts result.
- res_data  out  N_BITS  decisions, first decision in MSB.
- res_chan  out  SEL_W  channel of res_data.
- overrun  out  1  sticky; a continuous-mode result was dropped.
- ovr_clr  in  1  clears overrun.

## Operation
- States: IDLE, INIT, SAMP, COMP, LOGIC, DONE.
- IDLE: on start with cfg_en=1 and cfg_mask≠0, latch cfg_cont, cfg_mask and the four durations into shadow registers. Then enter INIT on the first enabled channel (lowest set bit). start with mask=0, cfg_en=0, or when not IDLE is ignored.
- Each phase lasts t+1 cycles from its shadow duration. The matching seq_* output is high for exactly those cycles.
- INIT→SAMP→COMP. COMP→LOGIC. LOGIC→COMP while bit_cnt < N_BITS, else LOGIC→DONE.
- Bit capture: comp_in is sampled on the last cycle of each COMP phase and shifted in MSB-first. bit_cnt increments at that sample.
- DONE lasts 1 cycle, all strobes low.
  - Slot empty, or emptied that cycle by res_ready: load res_data and res_chan.
  - Slot full in single-shot: stay in DONE (stall) until res_ready.
  - Slot full in continuous: drop the result and set overrun.
- Next channel is the next set shadow-mask bit above the current one.
  - Single-shot: after the highest set bit, go to IDLE.
  - Continuous: wrap to the lowest set bit and continue until cfg_en=0.
- mux_sel updates on INIT entry and holds through DONE.
- cfg_en=0 in any state: IDLE next cycle, strobes low, partial result discarded. res_valid, res_data and res_chan are untouched. overrun is held.
- Handshake: res_valid falls the cycle after res_valid&res_ready unless reloaded in the same cycle. If reloaded in the same cycle, res_valid stays high with the new data.
- ovr_clr has priority over a same-cycle overrun set.

## Timing
- Reset values: all strobes 0, busy 0, mux_sel 0, res_valid 0, res_data 0, res_chan 0, overrun 0, state IDLE.
- start sampled in cycle k: INIT and seq_init high from k+1.
- Conversion length is Lc = (t_init+1) + (t_samp+1) + N_BITS·((t_comp+1) + (t_logic+1)) cycles, plus 1 DONE cycle.
- res_valid rises the cycle after DONE.
- Continuous mode: the next INIT immediately follows DONE, with no gap.
- Counters saturate-free: CNT_W wide, compared for equality with the shadow value.
- bit_cnt is $clog2(N_BITS+1) wide.

## Structure
- Package frida_seq_pkg holds:
  - the state enum;
  - a phase-index constant;
  - localparam helpers for SEL_W and bit-count width.
- Sub-module frida_chan_pick: combinational next-set-bit finder over the shadow mask. Inputs are mask and current channel; outputs are next, wrapped, and none.
- All remaining logic (FSM, phase counter, shift register, result slot) lives in frida_scan_seq.

## Test plan
- Single-shot basic: N_ADC=16, N_BITS=8, mask=16'h0005, all t=0, res_ready=1, comp_in pattern 1,0,1,1,0,0,1,0.
  - Expect two results: chan 0 then chan 2, each res_data=8'hB2.
  - Each conversion is 18 strobe cycles plus DONE; busy falls after the second DONE.
- Durations: t_init=2, t_samp=3, t_comp=1, t_logic=0.
  - Expect seq_init 3 cycles, seq_samp 4, each seq_comp 2, each seq_logic 1.
  - Expect comp_in sampled on the second seq_comp cycle.
- Backpressure: single-shot, mask=16'h0003, res_ready=0 throughout.
  - Expect FSM to stall in DONE after chan 1 with chan 0 result held.
  - Raising res_ready: chan 1 loads the following cycle.
- Continuous overrun: cfg_cont=1, mask=16'h8001, res_ready=0.
  - Expect mux_sel sequence 0,15,0 wrapping, overrun set on the second DONE, res_chan stays 0.
  - ovr_clr clears overrun.
- Abort and reset: cfg_en=0 during the 4th COMP → IDLE next cycle, strobes 0, res_valid unchanged.
  - rst mid-SAMP → all outputs at reset values next cycle.
  - start with mask=0 → busy stays 0.
